// File: rtl/grf_writeback_if.sv
// MEM -> WB instruction bundle: the fields the writeback stage captures each cycle.
interface grf_writeback_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_RegWrite;
    logic          in_RegDst;
    logic          in_JL;
    logic          in_MemToReg;
    logic [AW-1:0] in_rt;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_mem;
    logic [DW-1:0] in_pc4;

    modport master (
        output in_valid, in_RegWrite, in_RegDst, in_JL, in_MemToReg,
        output in_rt, in_rd, in_alu, in_mem, in_pc4
    );

    modport slave (
        input in_valid, in_RegWrite, in_RegDst, in_JL, in_MemToReg,
        input in_rt, in_rd, in_alu, in_mem, in_pc4
    );
endinterface

// File: rtl/grf_writeback.sv
// Writeback stage: MEM/WB register, GRF write-port driver and WB->ID read bypass.
// Optional GRF_WB_TRACE_EN adds a write counter port and a per-write trace print.
module grf_writeback #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          Reset_n,
    grf_writeback_if.slave mem_wb,
    input  logic          hold,
    input  logic          flush,
    input  logic [AW-1:0] Rs,
    input  logic [AW-1:0] Rt,
    input  logic [DW-1:0] RsData,
    input  logic [DW-1:0] RtData,
    output logic [AW-1:0] Rd,
    output logic [DW-1:0] Input,
    output logic          WriteEn,
    output logic [DW-1:0] fwd_RsData,
    output logic [DW-1:0] fwd_RtData
`ifdef GRF_WB_TRACE_EN
    ,
    output logic [31:0]   wb_count
`endif
);

    logic          wb_valid;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;

    // JL wins over both RegDst and MemToReg.
    always_comb begin
        dest = mem_wb.in_rt;
        data = mem_wb.in_alu;
        if (mem_wb.in_JL) begin
            dest = AW'(LINK_REG);
            data = mem_wb.in_pc4;
        end else begin
            if (mem_wb.in_RegDst)
                dest = mem_wb.in_rd;
            if (mem_wb.in_MemToReg)
                data = mem_wb.in_mem;
        end
    end

    // Writes to $0 are discarded here so they can never reach the GRF or the bypass.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wb_valid <= 1'b0;
            Rd       <= '0;
            Input    <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!hold) begin
            if (mem_wb.in_valid) begin
                wb_valid <= mem_wb.in_RegWrite && (dest != '0);
                Rd       <= dest;
                Input    <= data;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign WriteEn = wb_valid & ~hold;

    // Bypass uses wb_valid, not WriteEn: a held entry is still the value that will land.
    assign fwd_RsData = (wb_valid && (Rd == Rs) && (Rs != '0)) ? Input : RsData;
    assign fwd_RtData = (wb_valid && (Rd == Rt) && (Rt != '0)) ? Input : RtData;

`ifdef GRF_WB_TRACE_EN
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)
            wb_count <= '0;
        else if (WriteEn)
            wb_count <= wb_count + 32'd1;
    end

    always @(posedge clk) begin
        if (WriteEn)
            $display("@%0t: $%0d <= %h", $time, Rd, Input);
    end
`endif

endmodule

// File: tb/tb_grf_writeback.sv
// Scoreboarded random + directed bench for grf_writeback against a spec-level model.
module tb_grf_writeback;

    typedef struct {
        logic        valid, regwrite, regdst, jl, memtoreg, hold, flush;
        logic [4:0]  rt, rd, rs_a, rt_a;
        logic [31:0] alu, mem, pc4, rsdata, rtdata;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
    } fwd_t;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        hold, flush;
    logic [4:0]  rs_addr, rt_addr, Rd;
    logic [31:0] rs_data, rt_data, Input, fwd_RsData, fwd_RtData;
    logic        WriteEn;
`ifdef GRF_WB_TRACE_EN
    logic [31:0] wb_count;
`endif

    grf_writeback_if #(.DW(32), .AW(5)) mif ();

    grf_writeback #(.DW(32), .AW(5), .LINK_REG(31)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .mem_wb     (mif.slave),
        .hold       (hold),
        .flush      (flush),
        .Rs         (rs_addr),
        .Rt         (rt_addr),
        .RsData     (rs_data),
        .RtData     (rt_data),
        .Rd         (Rd),
        .Input      (Input),
        .WriteEn    (WriteEn),
        .fwd_RsData (fwd_RsData),
        .fwd_RtData (fwd_RtData)
`ifdef GRF_WB_TRACE_EN
        ,
        .wb_count   (wb_count)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 0;
    wr_t  wq[$];
    fwd_t fq[$];

    // Reference model: the single pending write the stage is holding, if any.
    bit          m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_count;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] destOf(input stim_t s);
        if (s.jl)     return 5'd31;
        if (s.regdst) return s.rd;
        return s.rt;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        s.rsdata = $urandom;
        s.rtdata = $urandom;
        return s;
    endfunction

    function automatic logic [4:0] pickReg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.valid    = ($urandom_range(0, 9) < 7);
        s.regwrite = ($urandom_range(0, 9) < 8);
        s.regdst   = 1'($urandom);
        s.jl       = ($urandom_range(0, 9) == 0);
        s.memtoreg = 1'($urandom);
        s.hold     = ($urandom_range(0, 9) < 2);
        s.flush    = ($urandom_range(0, 9) == 0);
        s.rt       = pickReg();
        s.rd       = pickReg();
        s.rs_a     = pickReg();
        s.rt_a     = pickReg();
        s.alu      = $urandom;
        s.mem      = $urandom;
        s.pc4      = $urandom;
        s.rsdata   = $urandom;
        s.rtdata   = $urandom;
        return s;
    endfunction

    task automatic driveInputs(input stim_t s);
        mif.in_valid    = s.valid;
        mif.in_RegWrite = s.regwrite;
        mif.in_RegDst   = s.regdst;
        mif.in_JL       = s.jl;
        mif.in_MemToReg = s.memtoreg;
        mif.in_rt       = s.rt;
        mif.in_rd       = s.rd;
        mif.in_alu      = s.alu;
        mif.in_mem      = s.mem;
        mif.in_pc4      = s.pc4;
        hold            = s.hold;
        flush           = s.flush;
        rs_addr         = s.rs_a;
        rt_addr         = s.rt_a;
        rs_data         = s.rsdata;
        rt_data         = s.rtdata;
    endtask

    // Called at posedge+1; drives one cycle, queues expectations, advances the model.
    task automatic applyStimulus(input stim_t s);
        wr_t        w;
        fwd_t       f;
        logic [4:0] d;
        driveInputs(s);
        cyc++;
        if (m_valid && !s.hold) begin
            w.cyc  = cyc;
            w.rd   = m_rd;
            w.data = m_data;
            wq.push_back(w);
            m_count++;
        end
        f.rs = (m_valid && m_rd == s.rs_a && s.rs_a != 0) ? m_data : s.rsdata;
        f.rt = (m_valid && m_rd == s.rt_a && s.rt_a != 0) ? m_data : s.rtdata;
        fq.push_back(f);
        @(posedge clk);
        if (s.flush) begin
            m_valid = 0;
        end else if (!s.hold) begin
            if (s.valid) begin
                d       = destOf(s);
                m_valid = s.regwrite && (d != 0);
                m_rd    = d;
                m_data  = s.jl ? s.pc4 : (s.memtoreg ? s.mem : s.alu);
            end else begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic doReset();
        stim_t s;
        mon_en = 0;
        checkOutput("queue_drained", 64'(wq.size()), 64'd0);
        wq.delete();
        fq.delete();
        s = randStim();
        s.rs_a = 5'd3;
        s.rt_a = 5'd3;
        driveInputs(s);
        Reset_n = 1'b0;
        #1;
        checkOutput("rst_writeen", 64'(WriteEn), 64'd0);
        checkOutput("rst_rd", 64'(Rd), 64'd0);
        checkOutput("rst_input", 64'(Input), 64'd0);
        checkOutput("rst_fwd_rs", 64'(fwd_RsData), 64'(s.rsdata));
        checkOutput("rst_fwd_rt", 64'(fwd_RtData), 64'(s.rtdata));
        m_valid = 0;
        m_count = 0;
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1'b1;
        mon_en  = 1;
    endtask

    task automatic midWriteReset();
        stim_t s;
        s          = idleStim();
        s.valid    = 1;
        s.regwrite = 1;
        s.regdst   = 1;
        s.rd       = 5'd12;
        s.alu      = 32'hCAFE_0012;
        applyStimulus(s);
        mon_en = 0;
        wq.delete();
        fq.delete();
        driveInputs(idleStim());
        #2;
        checkOutput("midrst_we_before", 64'(WriteEn), 64'd1);
        Reset_n = 1'b0;
        #1;
        checkOutput("midrst_we_after", 64'(WriteEn), 64'd0);
        checkOutput("midrst_rd", 64'(Rd), 64'd0);
        m_valid = 0;
        m_count = 0;
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
        mon_en  = 1;
    endtask

    // Monitor: fwd checked every cycle, writes popped whenever the DUT asserts WriteEn.
    always @(negedge clk) begin
        fwd_t f;
        wr_t  w;
        if (mon_en) begin
            if (fq.size() > 0) begin
                f = fq.pop_front();
                checkOutput("fwd_rs", 64'(fwd_RsData), 64'(f.rs));
                checkOutput("fwd_rt", 64'(fwd_RtData), 64'(f.rt));
            end
            if (WriteEn) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL spurious_write: WriteEn=1 Rd=%0d Input=%h, none expected (cycle %0d)",
                             Rd, Input, cyc);
                end else begin
                    w = wq.pop_front();
                    checkOutput("write_cycle", 64'(cyc), 64'(w.cyc));
                    checkOutput("write_rd", 64'(Rd), 64'(w.rd));
                    checkOutput("write_data", 64'(Input), 64'(w.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        Reset_n = 1'b0;
        m_valid = 0;
        m_count = 0;
        driveInputs(idleStim());
        @(posedge clk);
        #1;
        doReset();

        // Plain R-type write
        s = idleStim(); s.valid = 1; s.regwrite = 1; s.regdst = 1; s.rd = 5'd8; s.alu = 32'h1234;
        applyStimulus(s);
        checkOutput("t2_rd", 64'(Rd), 64'd8);
        checkOutput("t2_input", 64'(Input), 64'h1234);
        applyStimulus(idleStim());
        applyStimulus(idleStim());

        // JL overrides RegDst; then a $0 write that must be dropped
        s = idleStim(); s.valid = 1; s.regwrite = 1; s.regdst = 1; s.jl = 1; s.rd = 5'd5;
        s.pc4 = 32'h3004; s.alu = 32'h7777;
        applyStimulus(s);
        checkOutput("t3_rd", 64'(Rd), 64'd31);
        checkOutput("t3_input", 64'(Input), 64'h3004);
        s = idleStim(); s.valid = 1; s.regwrite = 1; s.rt = 5'd0; s.alu = 32'h5555;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());

        // Load captured then held for three cycles
        s = idleStim(); s.valid = 1; s.regwrite = 1; s.memtoreg = 1; s.rt = 5'd9; s.mem = 32'hDEAD;
        applyStimulus(s);
        checkOutput("t4_rd", 64'(Rd), 64'd9);
        for (int i = 0; i < 3; i++) begin
            s = idleStim(); s.hold = 1; s.valid = 1; s.regwrite = 1; s.rd = 5'd4; s.regdst = 1;
            s.rs_a = 5'd9;
            applyStimulus(s);
            checkOutput("t4_hold_we", 64'(WriteEn), 64'd0);
            checkOutput("t4_hold_fwd", 64'(fwd_RsData), 64'hDEAD);
        end
        applyStimulus(idleStim());
        applyStimulus(idleStim());

        // Flush beats hold and a simultaneous capture, and discards the pending entry
        s = idleStim(); s.valid = 1; s.regwrite = 1; s.regdst = 1; s.rd = 5'd6; s.alu = 32'h66;
        applyStimulus(s);
        s = idleStim(); s.valid = 1; s.regwrite = 1; s.regdst = 1; s.rd = 5'd7; s.alu = 32'h77;
        s.hold = 1; s.flush = 1; s.rs_a = 5'd6; s.rt_a = 5'd7;
        applyStimulus(s);
        checkOutput("t5_fwd_rs_raw", 64'(fwd_RsData), 64'(s.rsdata));
        checkOutput("t5_fwd_rt_raw", 64'(fwd_RtData), 64'(s.rtdata));
        applyStimulus(idleStim());

        // Back-to-back writes to $3
        doReset();
        s = idleStim(); s.valid = 1; s.regwrite = 1; s.regdst = 1; s.rd = 5'd3; s.alu = 32'hA;
        s.rs_a = 5'd3; s.rt_a = 5'd3;
        applyStimulus(s);
        checkOutput("t6_first", 64'(Input), 64'hA);
        s.alu = 32'hB;
        applyStimulus(s);
        checkOutput("t6_second", 64'(Input), 64'hB);
        s = idleStim(); s.rs_a = 5'd3; s.rt_a = 5'd3;
        applyStimulus(s);
        applyStimulus(idleStim());
`ifdef GRF_WB_TRACE_EN
        checkOutput("t6_wb_count", 64'(wb_count), 64'd2);
`endif

        midWriteReset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0)
                doReset();
            applyStimulus(randStim());
        end
        applyStimulus(idleStim());
        applyStimulus(idleStim());
`ifdef GRF_WB_TRACE_EN
        checkOutput("final_wb_count", 64'(wb_count), 64'(m_count));
`endif
        checkOutput("final_queue_empty", 64'(wq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
